// File: rtl/stream_demux_fifo.sv
// stream_demux_fifo: routes a valid/ready stream into one of NUM_OUT per-channel FIFOs,
// with broadcast to all channels and flagged discard of out-of-range selects.
module stream_demux_fifo #(
    parameter int NUM_OUT = 6,
    parameter int ELEM_WIDTH = 8,
    parameter int DEPTH = 4,
    localparam int SW = $clog2(NUM_OUT),
    localparam int AW = $clog2(DEPTH),
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic                                clk_i,
    input  logic                                arst_ni,
    input  logic [SW-1:0]                       s_i,
    input  logic                                bcast_i,
    input  logic [ELEM_WIDTH-1:0]               i_data_i,
    input  logic                                i_valid_i,
    output logic                                i_ready_o,
    output logic [NUM_OUT-1:0][ELEM_WIDTH-1:0]  o_data_o,
    output logic [NUM_OUT-1:0]                  o_valid_o,
    input  logic [NUM_OUT-1:0]                  o_ready_i,
    output logic [NUM_OUT-1:0][CW-1:0]          count_o,
    output logic                                drop_o
);
    logic [NUM_OUT-1:0] full, sel, push;
    logic accept;

    // An out-of-range select matches no channel, so it is never blocked by a full FIFO.
    assign i_ready_o = arst_ni && (bcast_i ? !(|full) : !(|(full & sel)));
    assign accept = i_valid_i && i_ready_o;

    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) drop_o <= 1'b0;
        else drop_o <= accept && !bcast_i && !(|sel);
    end

    for (genvar k = 0; k < NUM_OUT; k++) begin : g_ch
        logic [AW:0] wr, rd;
        logic [ELEM_WIDTH-1:0] mem [DEPTH];
        logic [ELEM_WIDTH-1:0] last;
        logic empty, pop;
        assign sel[k] = !bcast_i && (s_i == SW'(k));
        assign push[k] = accept && (bcast_i || sel[k]);
        assign empty = wr == rd;
        assign full[k] = (wr[AW] != rd[AW]) && (wr[AW-1:0] == rd[AW-1:0]);
        assign pop = !empty && o_ready_i[k];
        assign o_valid_o[k] = !empty;
        // When empty, present the last popped value rather than a stale slot.
        assign o_data_o[k] = empty ? last : mem[rd[AW-1:0]];
        assign count_o[k] = CW'(wr - rd);
        always_ff @(posedge clk_i or negedge arst_ni) begin
            if (!arst_ni) begin
                wr <= '0;
                rd <= '0;
                last <= '0;
            end else begin
                if (push[k]) wr <= wr + 1'b1;
                if (pop) begin
                    rd <= rd + 1'b1;
                    last <= mem[rd[AW-1:0]];
                end
            end
        end
        always_ff @(posedge clk_i) begin
            if (push[k]) mem[wr[AW-1:0]] <= i_data_i;
        end
    end
endmodule

// File: tb/tb_stream_demux_fifo.sv
// tb_stream_demux_fifo: directed vectors with hand-computed expectations for stream_demux_fifo.
module tb_stream_demux_fifo;
    localparam int NUM_OUT = 6;
    localparam int ELEM_WIDTH = 8;
    localparam int DEPTH = 4;
    localparam int CW = $clog2(DEPTH + 1);

    logic clk_i = 1'b0;
    logic arst_ni;
    logic [2:0] s_i;
    logic bcast_i;
    logic [ELEM_WIDTH-1:0] i_data_i;
    logic i_valid_i;
    logic i_ready_o;
    logic [NUM_OUT-1:0][ELEM_WIDTH-1:0] o_data_o;
    logic [NUM_OUT-1:0] o_valid_o;
    logic [NUM_OUT-1:0] o_ready_i;
    logic [NUM_OUT-1:0][CW-1:0] count_o;
    logic drop_o;

    int vectors = 0;
    int miscompares = 0;

    stream_demux_fifo #(.NUM_OUT(NUM_OUT), .ELEM_WIDTH(ELEM_WIDTH), .DEPTH(DEPTH)) dut (
        .clk_i(clk_i), .arst_ni(arst_ni), .s_i(s_i), .bcast_i(bcast_i),
        .i_data_i(i_data_i), .i_valid_i(i_valid_i), .i_ready_o(i_ready_o),
        .o_data_o(o_data_o), .o_valid_o(o_valid_o), .o_ready_i(o_ready_i),
        .count_o(count_o), .drop_o(drop_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic push_beat(input logic [2:0] s, input logic [7:0] d);
        s_i = s;
        i_data_i = d;
        i_valid_i = 1'b1;
        bcast_i = 1'b0;
        step();
        i_valid_i = 1'b0;
    endtask

    initial begin
        arst_ni = 1'b0;
        s_i = '0;
        bcast_i = 1'b0;
        i_data_i = '0;
        i_valid_i = 1'b0;
        o_ready_i = '0;
        #3;
        chk("rst_ready", i_ready_o, 0);
        chk("rst_valid", o_valid_o, 0);
        chk("rst_count", count_o, 0);
        chk("rst_data", o_data_o, 0);
        chk("rst_drop", drop_o, 0);
        step();
        step();
        arst_ni = 1'b1;
        step();

        // single beat to channel 2
        s_i = 3'd2;
        i_data_i = 8'hA5;
        i_valid_i = 1'b1;
        #1;
        chk("t1_ready", i_ready_o, 1);
        step();
        i_valid_i = 1'b0;
        chk("t1_valid", o_valid_o, 6'b000100);
        chk("t1_data", o_data_o[2], 8'hA5);
        chk("t1_count", count_o[2], 1);
        o_ready_i = 6'b000100;
        step();
        o_ready_i = '0;
        chk("t1_count_pop", count_o[2], 0);
        chk("t1_valid_pop", o_valid_o, 0);
        chk("t1_data_hold", o_data_o[2], 8'hA5);

        // fill channel 1, fifth beat stalls until a slot frees
        for (int i = 0; i < 5; i++) begin
            s_i = 3'd1;
            i_data_i = 8'h10 + 8'(i);
            i_valid_i = 1'b1;
            #1;
            chk("t2_ready", i_ready_o, (i < 4) ? 1 : 0);
            if (i < 4) step();
        end
        chk("t2_full_count", count_o[1], 4);
        o_ready_i = 6'b000010;
        #1;
        chk("t2_ready_still_low", i_ready_o, 0);
        chk("t2_d0", o_data_o[1], 8'h10);
        step();
        chk("t2_d1", o_data_o[1], 8'h11);
        chk("t2_ready_freed", i_ready_o, 1);
        step();
        i_valid_i = 1'b0;
        chk("t2_d2", o_data_o[1], 8'h12);
        chk("t2_count3", count_o[1], 3);
        step();
        chk("t2_d3", o_data_o[1], 8'h13);
        step();
        chk("t2_d4", o_data_o[1], 8'h14);
        step();
        chk("t2_empty", o_valid_o[1], 0);
        o_ready_i = '0;

        // channel 0 full does not block channel 3
        for (int i = 0; i < 4; i++) push_beat(3'd0, 8'h20 + 8'(i));
        s_i = 3'd3;
        i_data_i = 8'h30;
        i_valid_i = 1'b1;
        #1;
        chk("t3_ready", i_ready_o, 1);
        step();
        i_valid_i = 1'b0;
        chk("t3_count3", count_o[3], 1);
        o_ready_i = 6'b001000;
        chk("t3_data3", o_data_o[3], 8'h30);
        step();
        chk("t3_drained", count_o[3], 0);
        chk("t3_ch0_stalled", count_o[0], 4);
        o_ready_i = 6'b000001;
        for (int i = 0; i < 4; i++) begin
            chk("t3_ch0_order", o_data_o[0], 8'h20 + 8'(i));
            step();
        end
        o_ready_i = '0;
        chk("t3_ch0_empty", o_valid_o, 0);

        // broadcast to empty channels
        bcast_i = 1'b1;
        s_i = 3'd5;
        i_data_i = 8'h3C;
        i_valid_i = 1'b1;
        #1;
        chk("t4_ready", i_ready_o, 1);
        step();
        i_valid_i = 1'b0;
        bcast_i = 1'b0;
        for (int k = 0; k < NUM_OUT; k++) begin
            chk("t4_count", count_o[k], 1);
            chk("t4_data", o_data_o[k], 8'h3C);
        end
        o_ready_i = '1;
        step();
        o_ready_i = '0;
        chk("t4_all_popped", o_valid_o, 0);

        // broadcast blocked by full channel 4
        for (int i = 0; i < 4; i++) push_beat(3'd4, 8'h40 + 8'(i));
        bcast_i = 1'b1;
        i_data_i = 8'h55;
        i_valid_i = 1'b1;
        #1;
        chk("t4_blocked", i_ready_o, 0);
        step();
        step();
        i_valid_i = 1'b0;
        bcast_i = 1'b0;
        chk("t4_no_write", o_valid_o, 6'b010000);
        chk("t4_ch4_count", count_o[4], 4);
        o_ready_i = 6'b010000;
        for (int i = 0; i < 4; i++) step();
        o_ready_i = '0;
        chk("t4_ch4_drained", count_o[4], 0);

        // out-of-range select is discarded with a one-cycle flag
        s_i = 3'd7;
        i_data_i = 8'h99;
        i_valid_i = 1'b1;
        #1;
        chk("t5_ready", i_ready_o, 1);
        chk("t5_drop_before", drop_o, 0);
        step();
        i_valid_i = 1'b0;
        chk("t5_drop", drop_o, 1);
        chk("t5_counts", count_o, 0);
        step();
        chk("t5_drop_clear", drop_o, 0);

        // steady push/pop on channel 2 at count 2
        push_beat(3'd2, 8'h60);
        push_beat(3'd2, 8'h61);
        o_ready_i = 6'b000100;
        s_i = 3'd2;
        i_valid_i = 1'b1;
        for (int i = 0; i < 10; i++) begin
            i_data_i = 8'h62 + 8'(i);
            #1;
            chk("t6_count", count_o[2], 2);
            chk("t6_order", o_data_o[2], 8'h60 + 8'(i));
            step();
        end
        #2;
        arst_ni = 1'b0;
        #1;
        chk("t6_arst_valid", o_valid_o, 0);
        chk("t6_arst_count", count_o, 0);
        chk("t6_arst_ready", i_ready_o, 0);
        i_valid_i = 1'b0;
        o_ready_i = '0;
        step();
        arst_ni = 1'b1;
        step();
        chk("t6_post_valid", o_valid_o, 0);
        chk("t6_post_drop", drop_o, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
